// File: rtl/seq_divider_8x4.sv
// Sequential restoring divider (2N/N bits), one quotient bit per clock, valid/ready on both sides.
// Optional DIV_SELFCHECK_EN: recompute quotient*divisor+remainder with vedic multipliers and flag mismatches.
`ifdef DIV_SELFCHECK_EN
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] pp [4];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_row
            for (genvar gj = 0; gj < 2; gj++) begin : g_col
                logic [1:0] a2, b2;
                logic       s1, c1, s2, c2;
                assign a2 = a[2*gi +: 2];
                assign b2 = b[2*gj +: 2];
                // 2x2 vertically-and-crosswise block
                assign s1 = (a2[1] & b2[0]) ^ (a2[0] & b2[1]);
                assign c1 = (a2[1] & b2[0]) & (a2[0] & b2[1]);
                assign s2 = (a2[1] & b2[1]) ^ c1;
                assign c2 = (a2[1] & b2[1]) & c1;
                assign pp[gi*2+gj] = {c2, s2, s1, a2[0] & b2[0]};
            end
        end
    endgenerate

    assign p = {4'b0, pp[0]} + {2'b0, pp[1], 2'b0} + {2'b0, pp[2], 2'b0} + {pp[3], 4'b0};
endmodule
`endif

module seq_divider_8x4 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero
`ifdef DIV_SELFCHECK_EN
    ,
    output logic           chk_err
`endif
);
    localparam int CW = $clog2(2*N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  count_reg;
    logic [2*N-1:0] dvd_reg;
    logic [2*N-2:0] quo_work_reg;
    logic [N-1:0]   dsr_reg, rem_work_reg;
    logic [2*N-1:0] quotient_reg;
    logic [N-1:0]   remainder_reg;
    logic           div_zero_reg;
    logic           accept, last_step, ge, chk_pend;
    logic [N:0]     r_shift, r_diff;
    logic [N-1:0]   r_new;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_step = (state_reg == RUN) && (count_reg == '0);

    // No borrow out of the N+1-bit subtract means the partial remainder covers the divisor.
    assign r_shift = {rem_work_reg, dvd_reg[2*N-1]};
    assign r_diff  = r_shift - {1'b0, dsr_reg};
    assign ge      = ~r_diff[N];
    assign r_new   = ge ? r_diff[N-1:0] : r_shift[N-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (divisor == '0) ? DONE : RUN;
            RUN:     if (count_reg == '0) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE) && !chk_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            quo_work_reg  <= '0;
            rem_work_reg  <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else if (accept) begin
            dvd_reg      <= dividend;
            dsr_reg      <= divisor;
            count_reg    <= CW'(2*N-1);
            quo_work_reg <= '0;
            rem_work_reg <= '0;
            if (divisor == '0) begin
                quotient_reg  <= '1;
                remainder_reg <= '0;
                div_zero_reg  <= 1'b1;
            end
        end else if (state_reg == RUN) begin
            dvd_reg      <= dvd_reg << 1;
            rem_work_reg <= r_new;
            quo_work_reg <= {quo_work_reg[2*N-3:0], ge};
            count_reg    <= count_reg - 1'b1;
            if (last_step) begin
                quotient_reg  <= {quo_work_reg, ge};
                remainder_reg <= r_new;
                div_zero_reg  <= 1'b0;
            end
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;

`ifdef DIV_SELFCHECK_EN
    generate
        if (N != 4) begin : g_bad_width
            $error("DIV_SELFCHECK_EN requires N == 4");
        end
    endgenerate

    logic [7:0]  dvd_orig_reg;
    logic        chk_pend_reg, chk_err_reg;
    logic [7:0]  pp_lo, pp_hi;
    logic [11:0] chk_sum;

    vedic_4x4 u_mul_lo (.a(quotient_reg[3:0]), .b(dsr_reg), .p(pp_lo));
    vedic_4x4 u_mul_hi (.a(quotient_reg[7:4]), .b(dsr_reg), .p(pp_hi));

    assign chk_sum = {4'b0, pp_lo} + {pp_hi, 4'b0} + {8'b0, remainder_reg};

    // The reconstruction runs in the extra DONE cycle that holds back out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_orig_reg <= '0;
            chk_pend_reg <= 1'b0;
            chk_err_reg  <= 1'b0;
        end else begin
            if (accept) dvd_orig_reg <= dividend;
            chk_pend_reg <= last_step;
            if (chk_pend_reg && (chk_sum != {4'b0, dvd_orig_reg})) chk_err_reg <= 1'b1;
        end
    end

    assign chk_pend = chk_pend_reg;
    assign chk_err  = chk_err_reg;
`else
    assign chk_pend = 1'b0;
`endif
endmodule
